// File: rtl/jt12_pkg.sv
// Shared definitions for the jt12 CPU bus front end: register map, FSM states,
// strobe indices and the channel-code helper.
package jt12_pkg;

   localparam logic [7:0] REG_MODE     = 8'h27;
   localparam logic [7:0] REG_KON      = 8'h28;
   localparam logic [7:0] REG_DT1      = 8'h30;
   localparam logic [7:0] REG_TL       = 8'h40;
   localparam logic [7:0] REG_KS_AR    = 8'h50;
   localparam logic [7:0] REG_AMEN_D1R = 8'h60;
   localparam logic [7:0] REG_D2R      = 8'h70;
   localparam logic [7:0] REG_D1L      = 8'h80;
   localparam logic [7:0] REG_SSGEG    = 8'h90;
   localparam logic [7:0] REG_FNUM_LO  = 8'hA0;
   localparam logic [7:0] REG_BLOCK    = 8'hA4;
   localparam logic [7:0] REG_CH3_FNUM = 8'hA8;
   localparam logic [7:0] REG_CH3_BLK  = 8'hAC;
   localparam logic [7:0] REG_ALG      = 8'hB0;
   localparam logic [7:0] REG_PMS      = 8'hB4;

   localparam int UP_KEYON    = 0;
   localparam int UP_ALG      = 1;
   localparam int UP_BLOCK    = 2;
   localparam int UP_FNUMLO   = 3;
   localparam int UP_PMS      = 4;
   localparam int UP_DT1      = 5;
   localparam int UP_TL       = 6;
   localparam int UP_KS_AR    = 7;
   localparam int UP_AMEN_D1R = 8;
   localparam int UP_D2R      = 9;
   localparam int UP_D1L      = 10;
   localparam int UP_SSGEG    = 11;
   localparam int UP_NUM      = 12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   typedef struct packed {
      logic [2:0]  block;
      logic [10:0] fnum;
   } ch3_reg_t;

   function automatic logic [2:0] ch_code(input logic part, input logic [1:0] low2);
      return {part, low2};
   endfunction

endpackage

// File: rtl/jt12_busif_ch3.sv
// CH3 effect-mode state: mode flag, shared fnum-hi/block latch and the three
// per-operator fnum/block registers for op1..op3.
module jt12_busif_ch3
   import jt12_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  din,
   input  logic        mode_we,
   input  logic        latch_we,
   input  logic        commit_we,
   input  logic [1:0]  commit_sel,
   output logic        effect,
   output logic [10:0] fnum_op1,
   output logic [10:0] fnum_op2,
   output logic [10:0] fnum_op3,
   output logic [2:0]  block_op1,
   output logic [2:0]  block_op2,
   output logic [2:0]  block_op3
);

   logic     effect_q, effect_d;
   logic [5:0] latch_q, latch_d;
   ch3_reg_t opr_q [3];
   ch3_reg_t opr_d [3];
   logic [1:0] idx;

   // Address low bits 1,2,0 map to op1,op2,op3
   assign idx = (commit_sel == 2'd0) ? 2'd2 : commit_sel - 2'd1;

   always_comb begin
      effect_d = effect_q;
      latch_d  = latch_q;
      for (int i = 0; i < 3; i++) opr_d[i] = opr_q[i];
      if (mode_we)  effect_d = (din[7:6] != 2'b00);
      if (latch_we) latch_d = din[5:0];
      if (commit_we) begin
         opr_d[idx].block = latch_q[5:3];
         opr_d[idx].fnum  = {latch_q[2:0], din};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         effect_q <= 1'b0;
         latch_q  <= '0;
         for (int i = 0; i < 3; i++) opr_q[i] <= '0;
      end else begin
         effect_q <= effect_d;
         latch_q  <= latch_d;
         for (int i = 0; i < 3; i++) opr_q[i] <= opr_d[i];
      end
   end

   assign effect    = effect_q;
   assign fnum_op1  = opr_q[0].fnum;
   assign fnum_op2  = opr_q[1].fnum;
   assign fnum_op3  = opr_q[2].fnum;
   assign block_op1 = opr_q[0].block;
   assign block_op2 = opr_q[1].block;
   assign block_op3 = opr_q[2].block;

endmodule

// File: rtl/jt12_busif.sv
// CPU write front end: latches the register address, decodes data writes into
// one-hot update strobes and holds each strobe through the ring busy handshake.
module jt12_busif
   import jt12_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clk_en,
   input  logic [7:0]  cpu_din,
   input  logic [1:0]  cpu_addr,
   input  logic        cpu_cs_n,
   input  logic        cpu_wr_n,
   output logic [7:0]  cpu_dout,
   output logic [7:0]  din,
   output logic [2:0]  ch,
   output logic [1:0]  op,
   output logic        up_keyon,
   output logic        up_alg,
   output logic        up_block,
   output logic        up_fnumlo,
   output logic        up_pms,
   output logic        up_dt1,
   output logic        up_tl,
   output logic        up_ks_ar,
   output logic        up_amen_d1r,
   output logic        up_d2r,
   output logic        up_d1l,
   output logic        up_ssgeg,
   input  logic        busy,
   output logic        effect,
   output logic [10:0] fnum_ch3op1,
   output logic [10:0] fnum_ch3op2,
   output logic [10:0] fnum_ch3op3,
   output logic [2:0]  block_ch3op1,
   output logic [2:0]  block_ch3op2,
   output logic [2:0]  block_ch3op3
);

   logic              wr, wr_last_q, wr_pulse, accept;
   logic [7:0]        selreg_q, selreg_d;
   logic              part_q, part_d;
   state_e            state_q, state_d;
   logic [7:0]        din_q, din_d;
   logic [2:0]        ch_q, ch_d;
   logic [1:0]        op_q, op_d;
   logic [UP_NUM-1:0] up_q, up_d, up_dec;
   logic              mode_dec, latch_dec, commit_dec;

   assign wr       = !cpu_cs_n && !cpu_wr_n;
   assign wr_pulse = wr && !wr_last_q;
   assign accept   = wr_pulse && cpu_addr[0] && (state_q == ST_IDLE);

   // Decode the selected register; low2==3 is never a valid channel
   always_comb begin
      up_dec     = '0;
      mode_dec   = 1'b0;
      latch_dec  = 1'b0;
      commit_dec = 1'b0;
      if (selreg_q == REG_MODE) begin
         mode_dec = !part_q;
      end else if (selreg_q == REG_KON) begin
         up_dec[UP_KEYON] = !part_q;
      end else if (selreg_q[1:0] != 2'd3) begin
         case ({selreg_q[7:4], 4'h0})
            REG_DT1:      up_dec[UP_DT1]      = 1'b1;
            REG_TL:       up_dec[UP_TL]       = 1'b1;
            REG_KS_AR:    up_dec[UP_KS_AR]    = 1'b1;
            REG_AMEN_D1R: up_dec[UP_AMEN_D1R] = 1'b1;
            REG_D2R:      up_dec[UP_D2R]      = 1'b1;
            REG_D1L:      up_dec[UP_D1L]      = 1'b1;
            REG_SSGEG:    up_dec[UP_SSGEG]    = 1'b1;
            default: begin
               case ({selreg_q[7:2], 2'b00})
                  REG_FNUM_LO:  up_dec[UP_FNUMLO] = 1'b1;
                  REG_BLOCK:    up_dec[UP_BLOCK]  = 1'b1;
                  REG_ALG:      up_dec[UP_ALG]    = 1'b1;
                  REG_PMS:      up_dec[UP_PMS]    = 1'b1;
                  REG_CH3_FNUM: commit_dec        = !part_q;
                  REG_CH3_BLK:  latch_dec         = !part_q;
                  default: ;
               endcase
            end
         endcase
      end
   end

   always_comb begin
      selreg_d = selreg_q;
      part_d   = part_q;
      state_d  = state_q;
      din_d    = din_q;
      ch_d     = ch_q;
      op_d     = op_q;
      up_d     = up_q;
      if (wr_pulse && !cpu_addr[0]) begin
         selreg_d = cpu_din;
         part_d   = cpu_addr[1];
      end
      case (state_q)
         ST_IDLE: begin
            if (accept && (up_dec != '0)) begin
               up_d    = up_dec;
               din_d   = cpu_din;
               ch_d    = ch_code(part_q, selreg_q[1:0]);
               op_d    = selreg_q[3:2];
               state_d = ST_ARM;
            end
         end
         ST_ARM:  if (clk_en && busy) state_d = ST_WAIT;
         ST_WAIT: begin
            if (clk_en && !busy) begin
               up_d    = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            up_d    = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_last_q <= 1'b0;
         selreg_q  <= '0;
         part_q    <= 1'b0;
         state_q   <= ST_IDLE;
         din_q     <= '0;
         ch_q      <= '0;
         op_q      <= '0;
         up_q      <= '0;
      end else begin
         wr_last_q <= wr;
         selreg_q  <= selreg_d;
         part_q    <= part_d;
         state_q   <= state_d;
         din_q     <= din_d;
         ch_q      <= ch_d;
         op_q      <= op_d;
         up_q      <= up_d;
      end
   end

   jt12_busif_ch3 u_ch3 (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (cpu_din),
      .mode_we    (accept && mode_dec),
      .latch_we   (accept && latch_dec),
      .commit_we  (accept && commit_dec),
      .commit_sel (selreg_q[1:0]),
      .effect     (effect),
      .fnum_op1   (fnum_ch3op1),
      .fnum_op2   (fnum_ch3op2),
      .fnum_op3   (fnum_ch3op3),
      .block_op1  (block_ch3op1),
      .block_op2  (block_ch3op2),
      .block_op3  (block_ch3op3)
   );

   assign cpu_dout    = {state_q != ST_IDLE, 7'b0};
   assign din         = din_q;
   assign ch          = ch_q;
   assign op          = op_q;
   assign up_keyon    = up_q[UP_KEYON];
   assign up_alg      = up_q[UP_ALG];
   assign up_block    = up_q[UP_BLOCK];
   assign up_fnumlo   = up_q[UP_FNUMLO];
   assign up_pms      = up_q[UP_PMS];
   assign up_dt1      = up_q[UP_DT1];
   assign up_tl       = up_q[UP_TL];
   assign up_ks_ar    = up_q[UP_KS_AR];
   assign up_amen_d1r = up_q[UP_AMEN_D1R];
   assign up_d2r      = up_q[UP_D2R];
   assign up_d1l      = up_q[UP_D1L];
   assign up_ssgeg    = up_q[UP_SSGEG];

endmodule

// File: tb/tb_jt12_busif.sv
// Directed bench for jt12_busif: bus writes, strobe handshake, CH3 effect regs, reset.
module tb_jt12_busif;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clk_en = 1'b0;
   logic [7:0]  cpu_din = 8'h00;
   logic [1:0]  cpu_addr = 2'b00;
   logic        cpu_cs_n = 1'b1;
   logic        cpu_wr_n = 1'b1;
   logic        busy = 1'b0;
   logic [7:0]  cpu_dout, din;
   logic [2:0]  ch;
   logic [1:0]  op;
   logic        up_keyon, up_alg, up_block, up_fnumlo, up_pms, up_dt1, up_tl;
   logic        up_ks_ar, up_amen_d1r, up_d2r, up_d1l, up_ssgeg, effect;
   logic [10:0] fnum_ch3op1, fnum_ch3op2, fnum_ch3op3;
   logic [2:0]  block_ch3op1, block_ch3op2, block_ch3op3;
   logic [11:0] ups;

   int checks = 0;
   int errors = 0;

   assign ups = {up_ssgeg, up_d1l, up_d2r, up_amen_d1r, up_ks_ar, up_tl,
                 up_dt1, up_pms, up_fnumlo, up_block, up_alg, up_keyon};

   always #5 clk = ~clk;

   jt12_busif dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .cpu_din(cpu_din),
      .cpu_addr(cpu_addr), .cpu_cs_n(cpu_cs_n), .cpu_wr_n(cpu_wr_n),
      .cpu_dout(cpu_dout), .din(din), .ch(ch), .op(op),
      .up_keyon(up_keyon), .up_alg(up_alg), .up_block(up_block),
      .up_fnumlo(up_fnumlo), .up_pms(up_pms), .up_dt1(up_dt1), .up_tl(up_tl),
      .up_ks_ar(up_ks_ar), .up_amen_d1r(up_amen_d1r), .up_d2r(up_d2r),
      .up_d1l(up_d1l), .up_ssgeg(up_ssgeg), .busy(busy), .effect(effect),
      .fnum_ch3op1(fnum_ch3op1), .fnum_ch3op2(fnum_ch3op2), .fnum_ch3op3(fnum_ch3op3),
      .block_ch3op1(block_ch3op1), .block_ch3op2(block_ch3op2), .block_ch3op3(block_ch3op3)
   );

   task automatic tick(input logic en);
      @(negedge clk);
      clk_en = en;
      @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      clk_en = 1'b0;
      cpu_addr = a; cpu_din = d; cpu_cs_n = 1'b0; cpu_wr_n = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      cpu_cs_n = 1'b1; cpu_wr_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic finish_txn();
      busy = 1'b1;
      tick(1'b1);
      busy = 1'b0;
      tick(1'b1);
      tick(1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #23;
      checks++;
      if ({cpu_dout, din, ch, op, ups, effect} !== 34'd0) begin
         errors++; $display("FAIL reset_outs: got %h expected 0", {cpu_dout, din, ch, op, ups, effect});
      end
      @(negedge clk); rst_n = 1'b1;
      tick(1'b1);
      checks++;
      if ({fnum_ch3op1, fnum_ch3op2, fnum_ch3op3, block_ch3op1, block_ch3op2, block_ch3op3} !== 42'd0) begin
         errors++; $display("FAIL reset_ch3: got %h expected 0", {fnum_ch3op1, fnum_ch3op2, fnum_ch3op3});
      end
      checks++;
      if (cpu_dout !== 8'h00 || ups !== 12'h000) begin
         errors++; $display("FAIL reset_release: dout %h ups %h expected 00 000", cpu_dout, ups);
      end
   endtask

   task automatic test_keyon();
      int held;
      bus_wr(2'b00, 8'h28);
      bus_wr(2'b01, 8'hF1);
      checks++;
      if (ups !== 12'h001 || din !== 8'hF1 || cpu_dout !== 8'h80) begin
         errors++; $display("FAIL keyon_strobe: ups %h din %h dout %h expected 001 f1 80", ups, din, cpu_dout);
      end
      tick(1'b1);
      checks++;
      if (ups !== 12'h001 || cpu_dout !== 8'h80) begin
         errors++; $display("FAIL keyon_arm_hold: ups %h dout %h expected 001 80", ups, cpu_dout);
      end
      busy = 1'b1;
      held = 0;
      for (int i = 0; i < 24; i++) begin
         tick(1'b1);
         if (up_keyon === 1'b1 && cpu_dout === 8'h80 && din === 8'hF1) held++;
      end
      checks++;
      if (held != 24) begin
         errors++; $display("FAIL keyon_busy_hold: held %0d cycles expected 24", held);
      end
      busy = 1'b0;
      tick(1'b0);
      checks++;
      if (up_keyon !== 1'b1) begin
         errors++; $display("FAIL keyon_no_clken: got %b expected 1", up_keyon);
      end
      tick(1'b1);
      checks++;
      if (ups !== 12'h000 || cpu_dout !== 8'h00) begin
         errors++; $display("FAIL keyon_release: ups %h dout %h expected 000 00", ups, cpu_dout);
      end
   endtask

   task automatic test_part2();
      bus_wr(2'b10, 8'h46);
      bus_wr(2'b11, 8'h7F);
      checks++;
      if (ups !== 12'h040 || ch !== 3'd6 || op !== 2'd1 || din !== 8'h7F) begin
         errors++; $display("FAIL part2_tl: ups %h ch %0d op %0d din %h expected 040 6 1 7f", ups, ch, op, din);
      end
      finish_txn();
      bus_wr(2'b10, 8'h4B);
      bus_wr(2'b11, 8'h10);
      checks++;
      if (ups !== 12'h000 || cpu_dout !== 8'h00) begin
         errors++; $display("FAIL part2_low2_3: ups %h dout %h expected 000 00", ups, cpu_dout);
      end
      bus_wr(2'b10, 8'hA5);
      bus_wr(2'b11, 8'h22);
      checks++;
      if (ups !== 12'h004 || ch !== 3'd5 || din !== 8'h22) begin
         errors++; $display("FAIL part2_block: ups %h ch %0d din %h expected 004 5 22", ups, ch, din);
      end
      finish_txn();
   endtask

   task automatic test_busy_write();
      bus_wr(2'b00, 8'h50);
      bus_wr(2'b01, 8'h12);
      busy = 1'b1;
      tick(1'b1);
      bus_wr(2'b01, 8'h55);
      checks++;
      if (din !== 8'h12 || ups !== 12'h080) begin
         errors++; $display("FAIL busy_data_ignored: din %h ups %h expected 12 080", din, ups);
      end
      bus_wr(2'b00, 8'h84);
      busy = 1'b0;
      tick(1'b1);
      tick(1'b1);
      tick(1'b1);
      checks++;
      if (ups !== 12'h000 || cpu_dout !== 8'h00) begin
         errors++; $display("FAIL busy_no_second: ups %h dout %h expected 000 00", ups, cpu_dout);
      end
      bus_wr(2'b01, 8'h9A);
      checks++;
      if (ups !== 12'h400 || din !== 8'h9A || op !== 2'd1 || ch !== 3'd0) begin
         errors++; $display("FAIL busy_addr_kept: ups %h din %h op %0d ch %0d expected 400 9a 1 0", ups, din, op, ch);
      end
      finish_txn();
   endtask

   task automatic test_ch3();
      bus_wr(2'b00, 8'h27);
      bus_wr(2'b01, 8'h40);
      checks++;
      if (effect !== 1'b1 || cpu_dout !== 8'h00 || ups !== 12'h000) begin
         errors++; $display("FAIL ch3_effect: effect %b dout %h ups %h expected 1 00 000", effect, cpu_dout, ups);
      end
      bus_wr(2'b00, 8'hAD);
      bus_wr(2'b01, 8'h2B);
      bus_wr(2'b00, 8'hA9);
      bus_wr(2'b01, 8'hCD);
      checks++;
      if (fnum_ch3op1 !== 11'h3CD || block_ch3op1 !== 3'd5 || cpu_dout !== 8'h00) begin
         errors++; $display("FAIL ch3_op1: fnum %h block %0d dout %h expected 3cd 5 00", fnum_ch3op1, block_ch3op1, cpu_dout);
      end
      bus_wr(2'b00, 8'hA8);
      bus_wr(2'b01, 8'h01);
      checks++;
      if (fnum_ch3op3 !== 11'h301 || block_ch3op3 !== 3'd5 || fnum_ch3op2 !== 11'h000) begin
         errors++; $display("FAIL ch3_op3: fnum %h block %0d op2 %h expected 301 5 000", fnum_ch3op3, block_ch3op3, fnum_ch3op2);
      end
      bus_wr(2'b10, 8'h27);
      bus_wr(2'b11, 8'h00);
      bus_wr(2'b10, 8'hAD);
      bus_wr(2'b11, 8'h00);
      bus_wr(2'b10, 8'hAA);
      bus_wr(2'b11, 8'h11);
      bus_wr(2'b10, 8'hA9);
      bus_wr(2'b11, 8'h22);
      checks++;
      if (effect !== 1'b1 || fnum_ch3op2 !== 11'h000 || fnum_ch3op1 !== 11'h3CD || cpu_dout !== 8'h00) begin
         errors++; $display("FAIL ch3_part2_ignored: effect %b op2 %h op1 %h dout %h expected 1 000 3cd 00",
                            effect, fnum_ch3op2, fnum_ch3op1, cpu_dout);
      end
      bus_wr(2'b00, 8'hAA);
      bus_wr(2'b01, 8'h77);
      checks++;
      if (fnum_ch3op2 !== 11'h377 || block_ch3op2 !== 3'd5) begin
         errors++; $display("FAIL ch3_op2: fnum %h block %0d expected 377 5", fnum_ch3op2, block_ch3op2);
      end
   endtask

   task automatic test_held_write();
      @(negedge clk);
      clk_en = 1'b0;
      cpu_addr = 2'b00; cpu_din = 8'h28; cpu_cs_n = 1'b0; cpu_wr_n = 1'b0;
      @(negedge clk);
      cpu_addr = 2'b01; cpu_din = 8'h05;
      cpu_cs_n = 1'b1; cpu_wr_n = 1'b1;
      @(negedge clk);
      cpu_cs_n = 1'b0; cpu_wr_n = 1'b0;
      @(posedge clk); #1;
      busy = 1'b1;
      tick(1'b1);
      busy = 1'b0;
      tick(1'b1);
      tick(1'b0);
      tick(1'b1);
      checks++;
      if (ups !== 12'h000 || cpu_dout !== 8'h00 || din !== 8'h05) begin
         errors++; $display("FAIL held_write_once: ups %h dout %h din %h expected 000 00 05", ups, cpu_dout, din);
      end
      @(negedge clk);
      cpu_cs_n = 1'b1; cpu_wr_n = 1'b1;
   endtask

   task automatic test_reset_mid();
      bus_wr(2'b00, 8'h81);
      bus_wr(2'b01, 8'h33);
      busy = 1'b1;
      tick(1'b1);
      checks++;
      if (ups !== 12'h400 || ch !== 3'd1 || cpu_dout !== 8'h80) begin
         errors++; $display("FAIL mid_wait: ups %h ch %0d dout %h expected 400 1 80", ups, ch, cpu_dout);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (up_d1l !== 1'b0 || effect !== 1'b0 || fnum_ch3op1 !== 11'h000 || cpu_dout !== 8'h00) begin
         errors++; $display("FAIL mid_reset: d1l %b effect %b fnum %h dout %h expected 0 0 000 00",
                            up_d1l, effect, fnum_ch3op1, cpu_dout);
      end
      busy = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      bus_wr(2'b00, 8'h28);
      bus_wr(2'b01, 8'h02);
      checks++;
      if (ups !== 12'h001 || din !== 8'h02 || cpu_dout !== 8'h80) begin
         errors++; $display("FAIL restart_strobe: ups %h din %h dout %h expected 001 02 80", ups, din, cpu_dout);
      end
      finish_txn();
      checks++;
      if (ups !== 12'h000 || cpu_dout !== 8'h00) begin
         errors++; $display("FAIL restart_done: ups %h dout %h expected 000 00", ups, cpu_dout);
      end
   endtask

   initial begin
      test_reset();
      test_keyon();
      test_part2();
      test_busy_write();
      test_ch3();
      test_held_write();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
